adc_cmd_sequencer: RTL and testbench

Command-side initiator and response-side consumer for the on-chip ADC sequencer core's Avalon-ST command/response interface. Walks a fixed channel list and issues one command per slot, honouring command_ready. Captures each matching response into a per-slot sample register and flags protocol errors. Sits between the ADC core and the application logic that reads converted samples.

---
 rtl/adc_seq_pkg.sv | 19 +
 rtl/adc_seq_slot_store.sv | 116 +++++++++++
 rtl/adc_cmd_sequencer.sv | 164 ++++++++++++++++
 tb/tb_adc_cmd_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// Shared widths, FSM state type and a sizing helper for the ADC command sequencer.
// The optional averaging datapath is selected by the ADC_SEQ_AVG_EN macro.
package adc_seq_pkg;

    localparam int ADC_CH_W   = 5;
    localparam int ADC_DATA_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2
    } adc_seq_state_e;

    // Index width that stays at least one bit wide for single-entry tables.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_seq_slot_store.sv
// Per-slot sample registers, "written since reset" flags and the registered read port.
// Averaging over 2^AVG_LOG2 accepted samples is compiled in with ADC_SEQ_AVG_EN.
module adc_seq_slot_store
    import adc_seq_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int AVG_LOG2  = 2,
    localparam int SLOT_W   = idx_width(NUM_SLOTS)
)(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [SLOT_W-1:0]     wr_slot_i,
    input  logic [ADC_DATA_W-1:0] wr_data_i,
    input  logic [SLOT_W-1:0]     rd_slot_i,
    output logic [ADC_DATA_W-1:0] rd_data_o,
    output logic [NUM_SLOTS-1:0]  sample_valid_o
);

    logic [ADC_DATA_W-1:0] sample_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  valid_q;
    logic [ADC_DATA_W-1:0] rd_data_q;
    logic [ADC_DATA_W-1:0] rd_data_d;
    logic                  commit;
    logic [ADC_DATA_W-1:0] commit_data;

`ifdef ADC_SEQ_AVG_EN
    localparam int ACC_W = ADC_DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_q [NUM_SLOTS];
    logic [CNT_W-1:0] cnt_q [NUM_SLOTS];
    logic [ACC_W-1:0] acc_sel;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_sel;

    // The sample that completes a group is folded into the sum before the shift.
    always_comb begin
        acc_sel = '0;
        cnt_sel = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (wr_slot_i == SLOT_W'(k)) begin
                acc_sel = acc_q[k];
                cnt_sel = cnt_q[k];
            end
        end
        acc_sum     = acc_sel + ACC_W'(wr_data_i);
        commit      = wr_en_i && (cnt_sel == CNT_LAST);
        commit_data = ADC_DATA_W'(acc_sum >> AVG_LOG2);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                acc_q[k] <= '0;
                cnt_q[k] <= '0;
            end
        end else if (wr_en_i) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (wr_slot_i == SLOT_W'(k)) begin
                    acc_q[k] <= commit ? '0 : acc_sum;
                    cnt_q[k] <= commit ? '0 : cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end
`else
    // Averaging depth has no effect without the averaging datapath.
    localparam int unused_avg_log2 = AVG_LOG2;

    assign commit      = wr_en_i;
    assign commit_data = wr_data_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                sample_q[k] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (commit && (wr_slot_i == SLOT_W'(k))) begin
                    sample_q[k] <= commit_data;
                    valid_q[k]  <= 1'b1;
                end
            end
        end
    end

    // A write landing on the slot being read bypasses into the read register.
    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (rd_slot_i == SLOT_W'(k)) begin
                rd_data_d = sample_q[k];
            end
        end
        if (commit && (wr_slot_i == rd_slot_i)) begin
            rd_data_d = commit_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o      = rd_data_q;
    assign sample_valid_o = valid_q;

endmodule

// File: rtl/adc_cmd_sequencer.sv
// Walks a fixed channel list issuing one ADC command per slot and captures the responses.
// Define ADC_SEQ_AVG_EN to average 2^AVG_LOG2 passes per slot before a sample is published.
module adc_cmd_sequencer
    import adc_seq_pkg::*;
#(
    parameter int                              NUM_SLOTS     = 4,
    parameter logic [ADC_CH_W*NUM_SLOTS-1:0]   SLOT_CHANNELS = {5'd4, 5'd3, 5'd2, 5'd1},
    parameter int                              TIMEOUT       = 1023,
    parameter int                              AVG_LOG2      = 2
)(
    input  logic                               clock_clk,
    input  logic                               reset_sink_reset,
    input  logic                               run,
    input  logic                               single,
    input  logic                               err_clear,
    output logic                               command_valid,
    output logic [ADC_CH_W-1:0]                command_channel,
    output logic                               command_startofpacket,
    output logic                               command_endofpacket,
    input  logic                               command_ready,
    input  logic                               response_valid,
    input  logic [ADC_CH_W-1:0]                response_channel,
    input  logic [ADC_DATA_W-1:0]              response_data,
    input  logic                               response_startofpacket,
    input  logic                               response_endofpacket,
    input  logic [idx_width(NUM_SLOTS)-1:0]    rd_slot,
    output logic [ADC_DATA_W-1:0]              rd_data,
    output logic [NUM_SLOTS-1:0]               sample_valid,
    output logic                               pass_done,
    output logic                               busy,
    output logic                               err_mismatch,
    output logic                               err_timeout
);

    localparam int SLOT_W = idx_width(NUM_SLOTS);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    adc_seq_state_e      state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                pass_done_q, pass_done_d;
    logic                err_mm_q, err_mm_d;
    logic                err_to_q, err_to_d;
    logic [ADC_CH_W-1:0] cur_ch;
    logic                set_mm;
    logic                set_to;
    logic                wr_en;
    logic                advance;

    // Packet framing is owned by the ADC core and is deliberately not checked here.
    logic unused_rsp_framing;
    assign unused_rsp_framing = response_startofpacket ^ response_endofpacket;

    always_comb begin
        cur_ch = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot_q == SLOT_W'(k)) begin
                cur_ch = SLOT_CHANNELS[k*ADC_CH_W +: ADC_CH_W];
            end
        end
    end

    // A response outside RSP is a protocol error; in RSP the timeout counter runs
    // until either a response or the TIMEOUT-th cycle ends the slot.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        tmo_d       = tmo_q;
        pass_done_d = 1'b0;
        set_mm      = 1'b0;
        set_to      = 1'b0;
        wr_en       = 1'b0;
        advance     = 1'b0;
        unique case (state_q)
            IDLE: begin
                set_mm = response_valid;
                if (run || single) begin
                    state_d = CMD;
                    slot_d  = '0;
                end
            end
            CMD: begin
                set_mm = response_valid;
                if (command_ready) begin
                    state_d = RSP;
                    tmo_d   = '0;
                end
            end
            RSP: begin
                if (response_valid) begin
                    wr_en   = (response_channel == cur_ch);
                    set_mm  = (response_channel != cur_ch);
                    advance = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    set_to  = 1'b1;
                    advance = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (slot_q == LAST_SLOT) begin
                pass_done_d = 1'b1;
                slot_d      = '0;
                state_d     = run ? CMD : IDLE;
            end else begin
                slot_d  = slot_q + 1'b1;
                state_d = CMD;
            end
        end
    end

    // A new error event outranks a simultaneous clear.
    assign err_mm_d = set_mm | (err_mm_q & ~err_clear);
    assign err_to_d = set_to | (err_to_q & ~err_clear);

    always_ff @(posedge clock_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            tmo_q       <= '0;
            pass_done_q <= 1'b0;
            err_mm_q    <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            tmo_q       <= tmo_d;
            pass_done_q <= pass_done_d;
            err_mm_q    <= err_mm_d;
            err_to_q    <= err_to_d;
        end
    end

    adc_seq_slot_store #(
        .NUM_SLOTS (NUM_SLOTS),
        .AVG_LOG2  (AVG_LOG2)
    ) u_slot_store (
        .clk_i          (clock_clk),
        .rst_i          (reset_sink_reset),
        .wr_en_i        (wr_en),
        .wr_slot_i      (slot_q),
        .wr_data_i      (response_data),
        .rd_slot_i      (rd_slot),
        .rd_data_o      (rd_data),
        .sample_valid_o (sample_valid)
    );

    // Command fields are forced to zero outside CMD so reset and idle read as all-zero.
    assign command_valid         = (state_q == CMD);
    assign command_channel       = command_valid ? cur_ch : '0;
    assign command_startofpacket = command_valid && (slot_q == '0);
    assign command_endofpacket   = command_valid && (slot_q == LAST_SLOT);
    assign busy                  = (state_q != IDLE);
    assign pass_done             = pass_done_q;
    assign err_mismatch          = err_mm_q;
    assign err_timeout           = err_to_q;

endmodule

// File: tb/tb_adc_cmd_sequencer.sv
// Directed-plus-random bench for adc_cmd_sequencer; the bench plays the ADC core and
// predicts samples and error flags from the channel list (ADC_SEQ_AVG_EN aware).
module tb_adc_cmd_sequencer;

    localparam int NSLOT = 4;
    localparam int TMO   = 15;
    localparam int AVGL  = 2;
`ifdef ADC_SEQ_AVG_EN
    localparam int AVG_N = 1 << AVGL;
`else
    localparam int AVG_N = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        single = 1'b0;
    logic        err_clear = 1'b0;
    logic        command_ready = 1'b0;
    logic        response_valid = 1'b0;
    logic [4:0]  response_channel = '0;
    logic [11:0] response_data = '0;
    logic        response_sop = 1'b0;
    logic        response_eop = 1'b0;
    logic [1:0]  rd_slot = '0;

    logic        command_valid;
    logic [4:0]  command_channel;
    logic        command_sop;
    logic        command_eop;
    logic [11:0] rd_data;
    logic [3:0]  sample_valid;
    logic        pass_done;
    logic        busy;
    logic        err_mismatch;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    // Reference model: channel list, published samples, partial averages and sticky flags.
    int          chanList [NSLOT] = '{1, 2, 3, 4};
    logic [11:0] expSample [NSLOT];
    int          accSum [NSLOT];
    int          accCnt [NSLOT];
    logic [3:0]  expValid;
    logic        expMm;
    logic        expTo;

    always #5 clk = ~clk;

    adc_cmd_sequencer #(
        .NUM_SLOTS     (NSLOT),
        .SLOT_CHANNELS ({5'd4, 5'd3, 5'd2, 5'd1}),
        .TIMEOUT       (TMO),
        .AVG_LOG2      (AVGL)
    ) dut (
        .clock_clk              (clk),
        .reset_sink_reset       (rst),
        .run                    (run),
        .single                 (single),
        .err_clear              (err_clear),
        .command_valid          (command_valid),
        .command_channel        (command_channel),
        .command_startofpacket  (command_sop),
        .command_endofpacket    (command_eop),
        .command_ready          (command_ready),
        .response_valid         (response_valid),
        .response_channel       (response_channel),
        .response_data          (response_data),
        .response_startofpacket (response_sop),
        .response_endofpacket   (response_eop),
        .rd_slot                (rd_slot),
        .rd_data                (rd_data),
        .sample_valid           (sample_valid),
        .pass_done              (pass_done),
        .busy                   (busy),
        .err_mismatch           (err_mismatch),
        .err_timeout            (err_timeout)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NSLOT; i++) begin
            expSample[i] = '0;
            accSum[i]    = 0;
            accCnt[i]    = 0;
        end
        expValid = '0;
        expMm    = 1'b0;
        expTo    = 1'b0;
    endtask

    // A slot publishes the truncated mean once AVG_N matching responses have arrived.
    task automatic modelAccept(input int s, input logic [11:0] d);
        accSum[s] += int'(d);
        accCnt[s]++;
        if (accCnt[s] == AVG_N) begin
            expSample[s] = 12'(accSum[s] / AVG_N);
            expValid[s]  = 1'b1;
            accSum[s]    = 0;
            accCnt[s]    = 0;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cmd_valid"}, command_valid, 0);
        checkOutput({tag, "_cmd_channel"}, command_channel, 0);
        checkOutput({tag, "_cmd_sop"}, command_sop, 0);
        checkOutput({tag, "_cmd_eop"}, command_eop, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_pass_done"}, pass_done, 0);
        checkOutput({tag, "_err_mismatch"}, err_mismatch, 0);
        checkOutput({tag, "_err_timeout"}, err_timeout, 0);
        checkOutput({tag, "_sample_valid"}, sample_valid, 0);
        checkOutput({tag, "_rd_data"}, rd_data, 0);
    endtask

    // Serve one slot as the ADC core. mode 0: matching response, 1: wrong channel,
    // 2: no response (timeout), 3: wrong channel with err_clear in the same cycle.
    task automatic applyStimulus(input int s, input int mode, input int readyDelay,
                                 input int rspDelay, input logic [11:0] data);
        int n = 0;
        while (command_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        checkOutput($sformatf("cmd_valid_s%0d", s), command_valid, 1);
        checkOutput($sformatf("cmd_channel_s%0d", s), command_channel, chanList[s]);
        checkOutput($sformatf("cmd_sop_s%0d", s), command_sop, (s == 0));
        checkOutput($sformatf("cmd_eop_s%0d", s), command_eop, (s == NSLOT - 1));
        for (int i = 0; i < readyDelay; i++) begin
            @(negedge clk);
            checkOutput($sformatf("hold_valid_s%0d", s), command_valid, 1);
            checkOutput($sformatf("hold_channel_s%0d", s), command_channel, chanList[s]);
        end
        command_ready = 1'b1;
        @(negedge clk);
        command_ready = 1'b0;
        rd_slot = 2'(s);
        checkOutput($sformatf("no_dup_s%0d", s), command_valid, 0);
        if (mode == 2) begin
            repeat (TMO - 1) @(negedge clk);
            checkOutput($sformatf("tmo_not_early_s%0d", s), err_timeout, expTo);
            checkOutput($sformatf("tmo_still_waiting_s%0d", s), command_valid, 0);
            @(negedge clk);
            expTo = 1'b1;
        end else begin
            repeat (rspDelay) @(negedge clk);
            response_valid   = 1'b1;
            response_channel = (mode == 0) ? 5'(chanList[s]) : 5'd7;
            response_data    = data;
            err_clear        = (mode == 3);
            @(negedge clk);
            response_valid = 1'b0;
            err_clear      = 1'b0;
            response_data  = 12'($urandom);
            if (mode == 0) begin
                modelAccept(s, data);
            end else begin
                expMm = 1'b1;
                if (mode == 3) expTo = 1'b0;
            end
        end
        checkOutput($sformatf("err_mismatch_s%0d", s), err_mismatch, expMm);
        checkOutput($sformatf("err_timeout_s%0d", s), err_timeout, expTo);
        checkOutput($sformatf("sample_valid_s%0d", s), sample_valid, expValid);
        checkOutput($sformatf("rd_data_s%0d", s), rd_data, expSample[s]);
        checkOutput($sformatf("pass_done_s%0d", s), pass_done, (s == NSLOT - 1));
        checkOutput($sformatf("next_cmd_s%0d", s), command_valid, (s < NSLOT - 1) || run);
    endtask

    // modes packs a 2-bit mode per slot, slot 0 in the low bits.
    task automatic runPass(input bit useSingle, input logic [7:0] modes, input int slowSlot,
                           input bit fixedData);
        logic [11:0] data;
        int          mode;
        if (useSingle) begin
            checkOutput("idle_before_single", busy, 0);
            single = 1'b1;
            @(negedge clk);
            single = 1'b0;
            checkOutput("single_latency", command_valid, 1);
        end
        for (int s = 0; s < NSLOT; s++) begin
            mode = int'(modes[2*s +: 2]);
            if (useSingle && s == 2) begin
                single = 1'b1;
                @(negedge clk);
                single = 1'b0;
            end
            data = fixedData ? 12'(12'h100 + s) : 12'($urandom);
            applyStimulus(s, mode, (s == slowSlot) ? 5 : int'($urandom_range(0, 2)),
                          fixedData ? 3 : int'($urandom_range(0, 3)), data);
        end
        checkOutput("busy_after_pass", busy, run);
        @(negedge clk);
        checkOutput("pass_done_one_cycle", pass_done, 0);
    endtask

    initial begin
        modelReset();
        @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_stays_idle", busy, 0);

        run = 1'b1;
        @(negedge clk);
        checkOutput("run_latency", command_valid, 1);
        runPass(1'b0, 8'h00, -1, 1'b1);
        runPass(1'b0, 8'h00, 1, 1'b0);
        runPass(1'b0, 8'b00_00_01_00, -1, 1'b0);

        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        expMm = 1'b0;
        expTo = 1'b0;
        checkOutput("err_clear_mismatch", err_mismatch, 0);
        checkOutput("err_clear_timeout", err_timeout, 0);

        run = 1'b0;
        runPass(1'b0, 8'b11_10_00_00, -1, 1'b0);
        checkOutput("idle_after_run_drop", busy, 0);

        for (int s = 0; s < NSLOT; s++) begin
            rd_slot = 2'(s);
            @(negedge clk);
            checkOutput($sformatf("readback_s%0d", s), rd_data, expSample[s]);
        end

        response_valid   = 1'b1;
        response_channel = 5'd1;
        @(negedge clk);
        response_valid = 1'b0;
        expMm = 1'b1;
        checkOutput("idle_response_mismatch", err_mismatch, expMm);
        checkOutput("idle_response_no_write", sample_valid, expValid);
        checkOutput("idle_response_stays_idle", busy, 0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        expMm = 1'b0;
        expTo = 1'b0;
        checkOutput("err_clear_again", err_mismatch, 0);

        for (int p = 0; p < 4; p++) begin
            runPass(1'b1, 8'h00, -1, 1'b0);
        end

        single = 1'b1;
        @(negedge clk);
        single = 1'b0;
        command_ready = 1'b1;
        @(negedge clk);
        command_ready = 1'b0;
        response_valid   = 1'b1;
        response_channel = 5'd1;
        #2 rst = 1'b1;
        #1 checkAllZero("reset_in_rsp");
        response_valid = 1'b0;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_reset", busy, 0);
        runPass(1'b1, 8'h00, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
